pe_weight_bank: RTL and testbench

//   Parametrised weight/bias store for a PE; successor to the fixed kernel/bias RAMs inside pe_incha_single.

---
 rtl/pe_weight_bank.sv | 189 ++++++++++++++++++
 tb/tb_pe_weight_bank.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_weight_bank.sv
// Weight/bias store for one PE: decodes the packed write bus, tracks which taps and biases
// are loaded, and returns a full kernel word plus bias one cycle after each read request.
module pe_weight_bank #(
    parameter int IN_CHANNEL  = 2,
    parameter int OUT_CHANNEL = 4,
    parameter int KERNEL_PTS  = 9,
    parameter int W_WIDTH     = 8,
    parameter int B_WIDTH     = 16,
    localparam int NPOS       = IN_CHANNEL * KERNEL_PTS,
    localparam int CH_W       = (OUT_CHANNEL > 1) ? $clog2(OUT_CHANNEL) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     weight_wr_en,
    input  logic [31:0]              weight_wr_addr,
    input  logic [B_WIDTH-1:0]       weight_wr_data,
    output logic                     wr_ack,
    output logic                     wr_err,
    output logic                     err_sticky,
    input  logic                     rd_req,
    input  logic [CH_W-1:0]          rd_ch,
    output logic                     rd_valid,
    output logic [W_WIDTH*NPOS-1:0]  rd_kernel,
    output logic [B_WIDTH-1:0]       rd_bias,
    output logic                     bank_ready
);

    localparam int POS_W = (NPOS > 1) ? $clog2(NPOS) : 1;
    localparam logic [7:0] OUT_CH8 = 8'(OUT_CHANNEL);
    localparam logic [7:0] NPOS8 = 8'(NPOS);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NPOS - 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(OUT_CHANNEL - 1);

    logic [W_WIDTH-1:0] kmem [OUT_CHANNEL][NPOS];
    logic [B_WIDTH-1:0] bmem [OUT_CHANNEL];

    logic [NPOS-1:0] tap_flag [OUT_CHANNEL];
    logic [NPOS-1:0] tap_next [OUT_CHANNEL];
    logic [OUT_CHANNEL-1:0] bias_flag, bias_next;
    logic ready_next;

    logic [CH_W-1:0] ptr_ch;
    logic [POS_W-1:0] ptr_pos;

    logic [7:0] cmd_type, a_ch8, a_pos8, ctrl;
    logic [CH_W-1:0] a_ch, k_ch;
    logic [POS_W-1:0] a_pos, k_pos;
    logic ch_in, pos_in;
    logic acc, rej, k_we, b_we, ptr_step, ptr_load, flags_clr, sticky_clr;
    logic unused_ctrl_bits;

    logic [2**CH_W-1:0] ch_ok;
    logic rd_bad;
    logic [W_WIDTH*NPOS-1:0] rd_word;

    assign cmd_type = weight_wr_addr[31:24];
    assign a_ch8    = weight_wr_addr[23:16];
    assign a_pos8   = weight_wr_addr[15:8];
    assign ctrl     = weight_wr_addr[7:0];
    assign a_ch     = a_ch8[CH_W-1:0];
    assign a_pos    = a_pos8[POS_W-1:0];
    assign ch_in    = (a_ch8 < OUT_CH8);
    assign pos_in   = (a_pos8 < NPOS8);
    assign unused_ctrl_bits = ^ctrl[7:3];

    // A rejected command, including a CTRL with an out-of-range pointer load, changes nothing.
    always_comb begin
        acc        = 1'b0;
        rej        = 1'b0;
        k_we       = 1'b0;
        b_we       = 1'b0;
        k_ch       = a_ch;
        k_pos      = a_pos;
        ptr_step   = 1'b0;
        ptr_load   = 1'b0;
        flags_clr  = 1'b0;
        sticky_clr = 1'b0;
        if (weight_wr_en) begin
            case (cmd_type)
                8'h00: begin
                    if (ch_in && pos_in) begin
                        acc  = 1'b1;
                        k_we = 1'b1;
                    end else begin
                        rej = 1'b1;
                    end
                end
                8'h01: begin
                    if (ch_in) begin
                        acc  = 1'b1;
                        b_we = 1'b1;
                    end else begin
                        rej = 1'b1;
                    end
                end
                8'h02: begin
                    acc      = 1'b1;
                    k_we     = 1'b1;
                    k_ch     = ptr_ch;
                    k_pos    = ptr_pos;
                    ptr_step = 1'b1;
                end
                8'h03: begin
                    if (ctrl[1] && !(ch_in && pos_in)) begin
                        rej = 1'b1;
                    end else begin
                        acc        = 1'b1;
                        flags_clr  = ctrl[0];
                        ptr_load   = ctrl[1];
                        sticky_clr = ctrl[2];
                    end
                end
                default: rej = 1'b1;
            endcase
        end
    end

    always_comb begin
        tap_next  = tap_flag;
        bias_next = bias_flag;
        if (flags_clr) begin
            for (int c = 0; c < OUT_CHANNEL; c++) tap_next[c] = '0;
            bias_next = '0;
        end
        if (k_we) tap_next[k_ch][k_pos] = 1'b1;
        if (b_we) bias_next[a_ch] = 1'b1;
        ready_next = &bias_next;
        for (int c = 0; c < OUT_CHANNEL; c++) ready_next = ready_next & (&tap_next[c]);
    end

    always_comb begin
        ch_ok = '0;
        for (int i = 0; i < 2**CH_W; i++) ch_ok[i] = (i < OUT_CHANNEL);
    end

    assign rd_bad = !ch_ok[rd_ch];

    always_comb begin
        rd_word = '0;
        for (int p = 0; p < NPOS; p++) rd_word[p*W_WIDTH +: W_WIDTH] = kmem[rd_ch][p];
    end

    // Storage is not reset; writes are held off while reset is asserted so nothing lands half-done.
    always_ff @(posedge clk) begin
        if (rst_n && k_we) kmem[k_ch][k_pos] <= weight_wr_data[W_WIDTH-1:0];
        if (rst_n && b_we) bmem[a_ch] <= weight_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            err_sticky <= 1'b0;
            rd_valid   <= 1'b0;
            rd_kernel  <= '0;
            rd_bias    <= '0;
            bank_ready <= 1'b0;
            bias_flag  <= '0;
            ptr_ch     <= '0;
            ptr_pos    <= '0;
            for (int c = 0; c < OUT_CHANNEL; c++) tap_flag[c] <= '0;
        end else begin
            wr_ack     <= acc;
            wr_err     <= rej;
            tap_flag   <= tap_next;
            bias_flag  <= bias_next;
            bank_ready <= ready_next;
            if (rej || (rd_req && rd_bad)) err_sticky <= 1'b1;
            else if (sticky_clr) err_sticky <= 1'b0;
            if (ptr_load) begin
                ptr_ch  <= a_ch;
                ptr_pos <= a_pos;
            end else if (ptr_step) begin
                if (ptr_pos == LAST_POS) begin
                    ptr_pos <= '0;
                    ptr_ch  <= (ptr_ch == LAST_CH) ? '0 : ptr_ch + 1'b1;
                end else begin
                    ptr_pos <= ptr_pos + 1'b1;
                end
            end
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_kernel <= rd_bad ? '0 : rd_word;
                rd_bias   <= rd_bad ? '0 : bmem[rd_ch];
            end
        end
    end

endmodule

// File: tb/tb_pe_weight_bank.sv
// Bench for pe_weight_bank: directed sequences, an error-vector table and random traffic,
// all checked against an array-based model of the bank.
module tb_pe_weight_bank;

    localparam int NP  = 18;
    localparam int NCH = 4;
    localparam int KW  = 8 * NP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            weight_wr_en;
    logic [31:0]     weight_wr_addr;
    logic [15:0]     weight_wr_data;
    logic            rd_req;
    logic [1:0]      rd_ch;
    logic            wr_ack, wr_err, err_sticky, rd_valid, bank_ready;
    logic [KW-1:0]   rd_kernel;
    logic [15:0]     rd_bias;
    logic            wr_ack3, wr_err3, err_sticky3, rd_valid3, bank_ready3;
    logic [KW-1:0]   rd_kernel3;
    logic [15:0]     rd_bias3;

    pe_weight_bank #(.IN_CHANNEL(2), .OUT_CHANNEL(4), .KERNEL_PTS(9), .W_WIDTH(8), .B_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .weight_wr_en(weight_wr_en), .weight_wr_addr(weight_wr_addr),
        .weight_wr_data(weight_wr_data), .wr_ack(wr_ack), .wr_err(wr_err), .err_sticky(err_sticky),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_valid(rd_valid), .rd_kernel(rd_kernel),
        .rd_bias(rd_bias), .bank_ready(bank_ready)
    );

    // Three-channel instance so an out-of-range read channel is expressible on a 2-bit rd_ch.
    pe_weight_bank #(.IN_CHANNEL(2), .OUT_CHANNEL(3), .KERNEL_PTS(9), .W_WIDTH(8), .B_WIDTH(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .weight_wr_en(weight_wr_en), .weight_wr_addr(weight_wr_addr),
        .weight_wr_data(weight_wr_data), .wr_ack(wr_ack3), .wr_err(wr_err3), .err_sticky(err_sticky3),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_valid(rd_valid3), .rd_kernel(rd_kernel3),
        .rd_bias(rd_bias3), .bank_ready(bank_ready3)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  km [NCH][NP];
    bit          kk [NCH][NP];
    bit          tl [NCH][NP];
    logic [15:0] bm [NCH];
    bit          bk [NCH];
    bit          bl [NCH];
    int          sptr;
    bit          sticky;
    bit          exp_rv;
    logic [KW-1:0] exp_k, exp_km;
    logic [15:0] exp_b, exp_bm;

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic [15:0] data;
        logic        exp_ack;
        logic        exp_err;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic bit all_loaded();
        bit r = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            r &= bl[c];
            for (int p = 0; p < NP; p++) r &= tl[c][p];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            bl[c] = 1'b0;
            for (int p = 0; p < NP; p++) tl[c][p] = 1'b0;
        end
        sptr = 0;
        sticky = 1'b0;
        exp_rv = 1'b0;
        exp_k = '0;
        exp_km = '1;
        exp_b = '0;
        exp_bm = '1;
    endtask

    task automatic do_cycle(input logic en, input logic [31:0] addr, input logic [15:0] data,
                            input logic rreq, input logic [1:0] rch);
        int ty, c, p, lin;
        logic [7:0] ctl;
        bit ack, err, clr;
        weight_wr_en = en;
        weight_wr_addr = addr;
        weight_wr_data = data;
        rd_req = rreq;
        rd_ch = rch;
        exp_rv = rreq;
        if (rreq) begin
            for (int q = 0; q < NP; q++) begin
                exp_k[q*8 +: 8] = km[rch][q];
                exp_km[q*8 +: 8] = kk[rch][q] ? 8'hFF : 8'h00;
            end
            exp_b = bm[rch];
            exp_bm = bk[rch] ? 16'hFFFF : 16'h0000;
        end
        ack = 1'b0;
        err = 1'b0;
        clr = 1'b0;
        if (en) begin
            ty = int'(addr[31:24]);
            c = int'(addr[23:16]);
            p = int'(addr[15:8]);
            ctl = addr[7:0];
            case (ty)
                0: if (c < NCH && p < NP) begin
                       km[c][p] = data[7:0]; kk[c][p] = 1'b1; tl[c][p] = 1'b1; ack = 1'b1;
                   end else err = 1'b1;
                1: if (c < NCH) begin
                       bm[c] = data; bk[c] = 1'b1; bl[c] = 1'b1; ack = 1'b1;
                   end else err = 1'b1;
                2: begin
                       lin = sptr;
                       km[lin / NP][lin % NP] = data[7:0];
                       kk[lin / NP][lin % NP] = 1'b1;
                       tl[lin / NP][lin % NP] = 1'b1;
                       sptr = (sptr + 1) % (NCH * NP);
                       ack = 1'b1;
                   end
                3: if (ctl[1] && !(c < NCH && p < NP)) err = 1'b1;
                   else begin
                       if (ctl[0]) begin
                           for (int a = 0; a < NCH; a++) begin
                               bl[a] = 1'b0;
                               for (int b = 0; b < NP; b++) tl[a][b] = 1'b0;
                           end
                       end
                       if (ctl[1]) sptr = c * NP + p;
                       clr = ctl[2];
                       ack = 1'b1;
                   end
                default: err = 1'b1;
            endcase
        end
        if (err) sticky = 1'b1;
        else if (clr) sticky = 1'b0;
        @(posedge clk);
        #1;
        chk("wr_ack", KW'(wr_ack), KW'(ack));
        chk("wr_err", KW'(wr_err), KW'(err));
        chk("err_sticky", KW'(err_sticky), KW'(sticky));
        chk("bank_ready", KW'(bank_ready), KW'(all_loaded()));
        chk("rd_valid", KW'(rd_valid), KW'(exp_rv));
        if (exp_km != '0) chk("rd_kernel", rd_kernel & exp_km, exp_k & exp_km);
        if (exp_bm != '0) chk("rd_bias", KW'(rd_bias & exp_bm), KW'(exp_b & exp_bm));
        weight_wr_en = 1'b0;
        rd_req = 1'b0;
    endtask

    initial begin
        logic [KW-1:0] w;
        logic [31:0] ra;
        int ty;
        weight_wr_en = 1'b0;
        weight_wr_addr = '0;
        weight_wr_data = '0;
        rd_req = 1'b0;
        rd_ch = '0;
        for (int c = 0; c < NCH; c++) begin
            bk[c] = 1'b0;
            bm[c] = '0;
            for (int p = 0; p < NP; p++) begin
                kk[c][p] = 1'b0;
                km[c][p] = '0;
            end
        end
        model_reset();

        tbl[0] = '{1'b1, {8'h00, 8'd4, 8'd0, 8'h00},  16'h0011, 1'b0, 1'b1};
        tbl[1] = '{1'b1, {8'h00, 8'd0, 8'd18, 8'h00}, 16'h0022, 1'b0, 1'b1};
        tbl[2] = '{1'b1, {8'h07, 8'd0, 8'd0, 8'h00},  16'h0033, 1'b0, 1'b1};
        tbl[3] = '{1'b1, {8'h01, 8'd4, 8'd0, 8'h00},  16'h0044, 1'b0, 1'b1};
        tbl[4] = '{1'b1, {8'h03, 8'd4, 8'd0, 8'h02},  16'h0000, 1'b0, 1'b1};
        tbl[5] = '{1'b1, {8'h00, 8'd3, 8'd17, 8'h00}, 16'h0055, 1'b1, 1'b0};
        tbl[6] = '{1'b1, {8'h01, 8'd3, 8'd0, 8'h00},  16'h1234, 1'b1, 1'b0};
        tbl[7] = '{1'b0, {8'h07, 8'd9, 8'd9, 8'h00},  16'h0000, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst_wr_ack", KW'(wr_ack), '0);
        chk("rst_rd_valid", KW'(rd_valid), '0);
        chk("rst_bank_ready", KW'(bank_ready), '0);
        chk("rst_err_sticky", KW'(err_sticky), '0);
        chk("rst_rd_kernel", rd_kernel, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Out-of-range read channel on the three-channel bank
        do_cycle(1'b0, '0, '0, 1'b1, 2'd3);
        chk("rderr_valid", KW'(rd_valid3), KW'(1'b1));
        chk("rderr_kernel", rd_kernel3, '0);
        chk("rderr_bias", KW'(rd_bias3), '0);
        chk("rderr_sticky", KW'(err_sticky3), KW'(1'b1));

        // Test 1: kernel writes ch0 pos0..17 = pos+10
        for (int p = 0; p < NP; p++) begin
            do_cycle(1'b1, {8'h00, 8'd0, 8'(p), 8'h00}, 16'(p + 10), 1'b0, 2'd0);
            chk("t1_ack", KW'(wr_ack), KW'(1'b1));
        end
        do_cycle(1'b0, '0, '0, 1'b1, 2'd0);
        for (int p = 0; p < NP; p++) w[p*8 +: 8] = 8'(p + 10);
        chk("t1_kernel", rd_kernel, w);

        // Test 2: biases, back-to-back reads
        do_cycle(1'b1, {8'h01, 8'd2, 8'd0, 8'h00}, 16'hFFCE, 1'b0, 2'd0);
        do_cycle(1'b1, {8'h01, 8'd3, 8'd0, 8'h00}, 16'h7FFF, 1'b0, 2'd0);
        do_cycle(1'b0, '0, '0, 1'b1, 2'd2);
        chk("t2_valid_a", KW'(rd_valid), KW'(1'b1));
        chk("t2_bias_a", KW'(rd_bias), KW'(16'hFFCE));
        do_cycle(1'b0, '0, '0, 1'b1, 2'd3);
        chk("t2_valid_b", KW'(rd_valid), KW'(1'b1));
        chk("t2_bias_b", KW'(rd_bias), KW'(16'h7FFF));
        do_cycle(1'b0, '0, '0, 1'b0, 2'd0);
        chk("t2_valid_off", KW'(rd_valid), '0);
        chk("t2_bias_hold", KW'(rd_bias), KW'(16'h7FFF));

        // Test 6a: read-before-write on the same channel
        do_cycle(1'b1, {8'h00, 8'd0, 8'd0, 8'h00}, 16'd42, 1'b1, 2'd0);
        chk("t6_old", KW'(rd_kernel[7:0]), KW'(8'd10));
        do_cycle(1'b0, '0, '0, 1'b1, 2'd0);
        chk("t6_new", KW'(rd_kernel[7:0]), KW'(8'd42));

        // Test 3: stream pointer across a channel boundary
        do_cycle(1'b1, {8'h03, 8'd1, 8'd16, 8'h02}, '0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) do_cycle(1'b1, {8'h02, 8'hFF, 8'hFF, 8'h00}, 16'(8'h80 + i), 1'b0, 2'd0);
        do_cycle(1'b0, '0, '0, 1'b1, 2'd1);
        chk("t3_ch1", KW'(rd_kernel[16*8 +: 16]), KW'(16'h8180));
        do_cycle(1'b0, '0, '0, 1'b1, 2'd2);
        chk("t3_ch2", KW'(rd_kernel[15:0]), KW'(16'h8382));

        // Test 4: full load via stream, then clear
        do_cycle(1'b1, {8'h03, 8'd0, 8'd0, 8'h03}, '0, 1'b0, 2'd0);
        for (int i = 0; i < NCH * NP; i++) do_cycle(1'b1, {8'h02, 8'd0, 8'd0, 8'h00}, 16'($urandom), 1'b0, 2'd0);
        chk("t4_not_ready", KW'(bank_ready), '0);
        for (int c = 0; c < NCH; c++) do_cycle(1'b1, {8'h01, 8'(c), 8'd0, 8'h00}, 16'($urandom), 1'b0, 2'd0);
        chk("t4_ready", KW'(bank_ready), KW'(1'b1));
        do_cycle(1'b1, {8'h03, 8'd0, 8'd0, 8'h01}, '0, 1'b0, 2'd0);
        chk("t4_cleared", KW'(bank_ready), '0);

        // Test 5: rejected commands from the table
        do_cycle(1'b1, {8'h03, 8'd0, 8'd0, 8'h04}, '0, 1'b0, 2'd0);
        chk("t5_sticky_pre", KW'(err_sticky), '0);
        for (int i = 0; i < 8; i++) begin
            do_cycle(tbl[i].en, tbl[i].addr, tbl[i].data, 1'b0, 2'd0);
            chk("t5_ack", KW'(wr_ack), KW'(tbl[i].exp_ack));
            chk("t5_err", KW'(wr_err), KW'(tbl[i].exp_err));
        end
        chk("t5_sticky", KW'(err_sticky), KW'(1'b1));
        do_cycle(1'b0, '0, '0, 1'b1, 2'd0);
        do_cycle(1'b1, {8'h03, 8'd0, 8'd0, 8'h04}, '0, 1'b0, 2'd0);
        chk("t5_sticky_clr", KW'(err_sticky), '0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0, 1: ty = 0;
                2: ty = 1;
                3: ty = 2;
                4: ty = 3;
                default: ty = 7;
            endcase
            ra = {8'(ty), 8'($urandom_range(0, 5)), 8'($urandom_range(0, 20)),
                  8'($urandom_range(0, 7) & (($urandom_range(0, 9) == 0) ? 7 : 6))};
            do_cycle(1'($urandom_range(0, 1)), ra, 16'($urandom), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)));
        end

        // Test 6b: reset in the middle of a stream
        do_cycle(1'b1, {8'h03, 8'd2, 8'd5, 8'h02}, '0, 1'b0, 2'd0);
        do_cycle(1'b1, {8'h02, 8'd0, 8'd0, 8'h00}, 16'h0011, 1'b0, 2'd0);
        weight_wr_en = 1'b1;
        weight_wr_addr = {8'h02, 8'd0, 8'd0, 8'h00};
        weight_wr_data = 16'h0022;
        rd_req = 1'b1;
        rd_ch = 2'd0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ack", KW'(wr_ack), '0);
        chk("t6_rst_valid", KW'(rd_valid), '0);
        chk("t6_rst_kernel", rd_kernel, '0);
        repeat (2) @(posedge clk);
        weight_wr_en = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_cycle(1'b1, {8'h02, 8'd3, 8'd3, 8'h00}, 16'h005A, 1'b0, 2'd0);
        do_cycle(1'b0, '0, '0, 1'b1, 2'd0);
        chk("t6_ptr_home", KW'(rd_kernel[7:0]), KW'(8'h5A));
        do_cycle(1'b0, '0, '0, 1'b1, 2'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
